// File: rtl/rgb888_to_yuv422.sv
// rgb888_to_yuv422: five-stage BT.601 RGB888 -> YUV 4:2:2 converter with matched sync/de delay.
// Define RGB2YUV_CHROMA_AVG_EN for pair-averaged chroma; otherwise chroma is decimated.
module rgb888_to_yuv422 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_v_sync,
    input  logic       i_h_sync,
    input  logic       i_de,
    input  logic [7:0] i_r_8b,
    input  logic [7:0] i_g_8b,
    input  logic [7:0] i_b_8b,
    output logic       o_v_sync,
    output logic       o_h_sync,
    output logic       o_de,
    output logic [7:0] y_out,
    output logic [7:0] c_out
);
    localparam int unsigned PW = 16;
    localparam int unsigned SW = 20;
    localparam int unsigned CW = 4;
    localparam logic signed [SW-1:0] ROUND = 128;
    localparam logic signed [SW-1:0] Y_OFF = 16;
    localparam logic signed [SW-1:0] C_OFF = 128;

    // control bundle bit positions: {phase, v_sync, h_sync, de}
    localparam int unsigned DE = 0;
    localparam int unsigned HS = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned PH = 3;

    function automatic logic [7:0] clamp8(input logic signed [SW-1:0] v);
        logic [7:0] r;
        if (v < 0)
            r = 8'd0;
        else if (v > 255)
            r = 8'd255;
        else
            r = v[7:0];
        return r;
    endfunction

`ifdef RGB2YUV_CHROMA_AVG_EN
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = 9'(a) + 9'(b) + 9'd1;
        return s[8:1];
    endfunction
`endif

    logic                 phase_q, phase_d;
    logic [CW-1:0]        ctl1_q, ctl1_d, ctl2_q, ctl2_d, ctl3_q, ctl3_d, ctl4_q, ctl4_d;
    logic [PW-1:0]        ry_q, gy_q, by_q, ru_q, gu_q, bu_q, rv_q, gv_q, bv_q;
    logic [PW-1:0]        ry_d, gy_d, by_d, ru_d, gu_d, bu_d, rv_d, gv_d, bv_d;
    logic signed [SW-1:0] sum_y_q, sum_cb_q, sum_cr_q, sum_y_d, sum_cb_d, sum_cr_d;
    logic [7:0]           y3_q, cb3_q, cr3_q, y3_d, cb3_d, cr3_d;
    logic [7:0]           y4_q, cb4_q, cr4_q, y4_d, cb4_d, cr4_d;
    logic                 o_v_sync_q, o_h_sync_q, o_de_q, o_v_sync_d, o_h_sync_d, o_de_d;
    logic [7:0]           y_q, c_q, y_d, c_d;
    logic [7:0]           cb_sel, cr_sel;
`ifdef RGB2YUV_CHROMA_AVG_EN
    logic [7:0]           prev_cr_q, prev_cr_d;
`endif

    always_comb begin
        // phase restarts even whenever de is low, so every line and every gap re-aligns pairs
        phase_d = i_de ? ~phase_q : 1'b0;
        ctl1_d  = {phase_q, i_v_sync, i_h_sync, i_de};
        ctl2_d  = ctl1_q;
        ctl3_d  = ctl2_q;
        ctl4_d  = ctl3_q;

        ry_d = PW'(i_r_8b) * PW'(66);
        gy_d = PW'(i_g_8b) * PW'(129);
        by_d = PW'(i_b_8b) * PW'(25);
        ru_d = PW'(i_r_8b) * PW'(38);
        gu_d = PW'(i_g_8b) * PW'(74);
        bu_d = PW'(i_b_8b) * PW'(112);
        rv_d = PW'(i_r_8b) * PW'(112);
        gv_d = PW'(i_g_8b) * PW'(94);
        bv_d = PW'(i_b_8b) * PW'(18);

        sum_y_d  = SW'(ry_q) + SW'(gy_q) + SW'(by_q) + ROUND;
        sum_cb_d = SW'(bu_q) - SW'(ru_q) - SW'(gu_q) + ROUND;
        sum_cr_d = SW'(rv_q) - SW'(gv_q) - SW'(bv_q) + ROUND;

        y3_d  = clamp8((sum_y_q >>> 8) + Y_OFF);
        cb3_d = clamp8((sum_cb_q >>> 8) + C_OFF);
        cr3_d = clamp8((sum_cr_q >>> 8) + C_OFF);

        y4_d  = y3_q;
        cb4_d = cb3_q;
        cr4_d = cr3_q;

        cb_sel = cb4_q;
        cr_sel = cr4_q;
`ifdef RGB2YUV_CHROMA_AVG_EN
        // even pixel peeks at stage 3 for its odd partner; odd pixel reuses the held even Cr
        prev_cr_d = cr4_q;
        if (ctl3_q[DE] && ctl3_q[PH])
            cb_sel = avg8(cb4_q, cb3_q);
        cr_sel = avg8(prev_cr_q, cr4_q);
`endif

        o_v_sync_d = ctl4_q[VS];
        o_h_sync_d = ctl4_q[HS];
        o_de_d     = ctl4_q[DE];
        y_d        = ctl4_q[DE] ? y4_q : 8'd0;
        c_d        = ctl4_q[DE] ? (ctl4_q[PH] ? cr_sel : cb_sel) : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= 1'b0;
            ctl1_q     <= '0;
            ctl2_q     <= '0;
            ctl3_q     <= '0;
            ctl4_q     <= '0;
            ry_q       <= '0;
            gy_q       <= '0;
            by_q       <= '0;
            ru_q       <= '0;
            gu_q       <= '0;
            bu_q       <= '0;
            rv_q       <= '0;
            gv_q       <= '0;
            bv_q       <= '0;
            sum_y_q    <= '0;
            sum_cb_q   <= '0;
            sum_cr_q   <= '0;
            y3_q       <= '0;
            cb3_q      <= '0;
            cr3_q      <= '0;
            y4_q       <= '0;
            cb4_q      <= '0;
            cr4_q      <= '0;
            o_v_sync_q <= 1'b0;
            o_h_sync_q <= 1'b0;
            o_de_q     <= 1'b0;
            y_q        <= '0;
            c_q        <= '0;
`ifdef RGB2YUV_CHROMA_AVG_EN
            prev_cr_q  <= '0;
`endif
        end else begin
            phase_q    <= phase_d;
            ctl1_q     <= ctl1_d;
            ctl2_q     <= ctl2_d;
            ctl3_q     <= ctl3_d;
            ctl4_q     <= ctl4_d;
            ry_q       <= ry_d;
            gy_q       <= gy_d;
            by_q       <= by_d;
            ru_q       <= ru_d;
            gu_q       <= gu_d;
            bu_q       <= bu_d;
            rv_q       <= rv_d;
            gv_q       <= gv_d;
            bv_q       <= bv_d;
            sum_y_q    <= sum_y_d;
            sum_cb_q   <= sum_cb_d;
            sum_cr_q   <= sum_cr_d;
            y3_q       <= y3_d;
            cb3_q      <= cb3_d;
            cr3_q      <= cr3_d;
            y4_q       <= y4_d;
            cb4_q      <= cb4_d;
            cr4_q      <= cr4_d;
            o_v_sync_q <= o_v_sync_d;
            o_h_sync_q <= o_h_sync_d;
            o_de_q     <= o_de_d;
            y_q        <= y_d;
            c_q        <= c_d;
`ifdef RGB2YUV_CHROMA_AVG_EN
            prev_cr_q  <= prev_cr_d;
`endif
        end
    end

    assign o_v_sync = o_v_sync_q;
    assign o_h_sync = o_h_sync_q;
    assign o_de     = o_de_q;
    assign y_out    = y_q;
    assign c_out    = c_q;

endmodule

// File: tb/tb_rgb888_to_yuv422.sv
// tb_rgb888_to_yuv422: directed table plus random stream, checked against a per-pixel BT.601 model.
// Honours RGB2YUV_CHROMA_AVG_EN the same way the design does.
module tb_rgb888_to_yuv422;
    localparam int MAXV = 8192;
    localparam int LAT  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_v_sync, i_h_sync, i_de;
    logic [7:0] i_r_8b, i_g_8b, i_b_8b;
    logic       o_v_sync, o_h_sync, o_de;
    logic [7:0] y_out, c_out;

    rgb888_to_yuv422 dut (
        .clk(clk), .rst_n(rst_n),
        .i_v_sync(i_v_sync), .i_h_sync(i_h_sync), .i_de(i_de),
        .i_r_8b(i_r_8b), .i_g_8b(i_g_8b), .i_b_8b(i_b_8b),
        .o_v_sync(o_v_sync), .o_h_sync(o_h_sync), .o_de(o_de),
        .y_out(y_out), .c_out(c_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r, g, b;
        bit de, hs;
        int ey, ec;
    } vec_t;

`ifdef RGB2YUV_CHROMA_AVG_EN
    localparam int RED_C = 165;
    localparam int BLU_C = 175;
`else
    localparam int RED_C = 90;
    localparam int BLU_C = 110;
`endif

    int vr[MAXV], vg[MAXV], vb[MAXV];
    bit vde[MAXV], vhs[MAXV], vvs[MAXV];
    bit tab_en[MAXV], ramp_en[MAXV];
    int tab_y[MAXV], tab_c[MAXV];
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    function automatic int fdiv256(input int t);
        int q;
        q = t / 256;
        if (t < 0 && (t % 256) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int sat(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    function automatic int y_of(input int j);
        return sat(fdiv256(66 * vr[j] + 129 * vg[j] + 25 * vb[j] + 128) + 16);
    endfunction

    function automatic int cb_of(input int j);
        return sat(fdiv256(-38 * vr[j] - 74 * vg[j] + 112 * vb[j] + 128) + 128);
    endfunction

    function automatic int cr_of(input int j);
        return sat(fdiv256(112 * vr[j] - 94 * vg[j] - 18 * vb[j] + 128) + 128);
    endfunction

    // position within the current run of de: 1st, 3rd, ... pixels are even
    function automatic bit is_odd(input int j);
        int n;
        n = 0;
        for (int k = j; k >= 0; k--) begin
            if (!vde[k]) break;
            n++;
        end
        return (n % 2) == 0;
    endfunction

    task automatic check_out(input int j);
        int ey, ec;
        bit ede, ehs, evs;
        ey = 0; ec = 0; ede = 0; ehs = 0; evs = 0;
        if (j >= 0) begin
            ede = vde[j]; ehs = vhs[j]; evs = vvs[j];
            if (vde[j]) begin
                ey = y_of(j);
                if (!is_odd(j)) begin
                    ec = cb_of(j);
`ifdef RGB2YUV_CHROMA_AVG_EN
                    if (vde[j + 1]) ec = (cb_of(j) + cb_of(j + 1) + 1) / 2;
`endif
                end else begin
                    ec = cr_of(j);
`ifdef RGB2YUV_CHROMA_AVG_EN
                    ec = (cr_of(j - 1) + cr_of(j) + 1) / 2;
`endif
                end
            end
        end
        n_vec++;
        if ({o_v_sync, o_h_sync, o_de} != {evs, ehs, ede} || int'(y_out) != ey || int'(c_out) != ec) begin
            n_bad++;
            $display("FAIL model idx=%0d got vs/hs/de=%b%b%b y=%0d c=%0d want %b%b%b y=%0d c=%0d",
                     j, o_v_sync, o_h_sync, o_de, y_out, c_out, evs, ehs, ede, ey, ec);
        end
        if (j >= 0 && tab_en[j]) begin
            n_vec++;
            if (o_de != vde[j] || int'(y_out) != tab_y[j] || int'(c_out) != tab_c[j]) begin
                n_bad++;
                $display("FAIL table idx=%0d got de=%b y=%0d c=%0d want de=%b y=%0d c=%0d",
                         j, o_de, y_out, c_out, vde[j], tab_y[j], tab_c[j]);
            end
        end
        if (j >= 0 && ramp_en[j]) begin
            int yy, cc, rr, gg, bb;
            yy = int'(y_out) - 16;
            cc = int'(c_out) - 128;
            rr = sat(fdiv256(298 * yy + 409 * cc + 128));
            gg = sat(fdiv256(298 * yy - 100 * cc - 208 * cc + 128));
            bb = sat(fdiv256(298 * yy + 516 * cc + 128));
            n_vec++;
            if (!o_de || rr < vr[j] - 2 || rr > vr[j] + 2 || gg < vr[j] - 2 || gg > vr[j] + 2 ||
                bb < vr[j] - 2 || bb > vr[j] + 2) begin
                n_bad++;
                $display("FAIL loopback k=%0d got de=%b rgb=%0d,%0d,%0d want within 2 of k",
                         vr[j], o_de, rr, gg, bb);
            end
        end
    endtask

    task automatic step(input int r, g, b, input bit de, hs, vs,
                        input bit te, input int ty, tc, input bit ramp);
        @(negedge clk);
        check_out(cyc - LAT);
        i_r_8b = 8'(r); i_g_8b = 8'(g); i_b_8b = 8'(b);
        i_de = de; i_h_sync = hs; i_v_sync = vs;
        vr[cyc] = r; vg[cyc] = g; vb[cyc] = b;
        vde[cyc] = de; vhs[cyc] = hs; vvs[cyc] = vs;
        tab_en[cyc] = te; tab_y[cyc] = ty; tab_c[cyc] = tc; ramp_en[cyc] = ramp;
        cyc++;
        if (cyc >= MAXV - 2) begin
            $display("FAIL vector store overflow at %0d", cyc);
            $fatal(1, "store overflow");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic rand_px(input bit de);
        step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             de, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if ({o_v_sync, o_h_sync, o_de} != 3'b000 || y_out != 8'd0 || c_out != 8'd0) begin
            n_bad++;
            $display("FAIL %s got vs/hs/de=%b%b%b y=%0d c=%0d want all 0",
                     tag, o_v_sync, o_h_sync, o_de, y_out, c_out);
        end
    endtask

    task automatic add(input int r, g, b, input bit de, hs, input int ey, ec);
        vec_t v;
        v.r = r; v.g = g; v.b = b; v.de = de; v.hs = hs; v.ey = ey; v.ec = ec;
        tbl.push_back(v);
    endtask

    // kills in-flight pixels in the model and checks the asynchronous clear
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        for (int k = cyc - LAT; k < cyc; k++) begin
            if (k >= 0) begin
                vde[k] = 1'b0; vhs[k] = 1'b0; vvs[k] = 1'b0; tab_en[k] = 1'b0; ramp_en[k] = 1'b0;
            end
        end
        idle(3);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_v_sync = 1'b0; i_h_sync = 1'b0; i_de = 1'b0;
        i_r_8b = 8'd0; i_g_8b = 8'd0; i_b_8b = 8'd0;
        #1 check_zero("reset_state");

        for (int i = 0; i < 4; i++) add(255, 255, 255, 1'b1, 1'b0, 235, 128);
        add(0, 0, 0, 1'b0, 1'b1, 0, 0);
        add(0, 0, 0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1'b1, 1'b0, 16, 128);
        add(0, 0, 0, 1'b0, 1'b1, 0, 0);
        add(255, 0, 0, 1'b1, 1'b0, 82, RED_C);
        add(0, 0, 255, 1'b1, 1'b0, 41, BLU_C);
        add(0, 0, 0, 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) add(255, 255, 255, 1'b1, 1'b0, 235, 128);
        add(0, 0, 0, 1'b0, 1'b1, 0, 0);
        add(0, 0, 0, 1'b0, 1'b0, 0, 0);
        add(255, 0, 0, 1'b1, 1'b0, 82, RED_C);
        add(0, 0, 255, 1'b1, 1'b0, 41, BLU_C);
        add(0, 0, 0, 1'b0, 1'b0, 0, 0);

        idle(3);
        rst_n = 1'b1;
        idle(2);

        foreach (tbl[i])
            step(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].de, tbl[i].hs, 1'b0, 1'b1, tbl[i].ey, tbl[i].ec, 1'b0);
        idle(3);

        for (int k = 0; k < 256; k++) step(k, k, k, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(3);

        for (int i = 0; i < 1500; i++)
            step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                 1'b0, 0, 0, 1'b0);
        idle(3);

        for (int i = 0; i < 3; i++) rand_px(1'b1);
        mid_reset();
        idle(2);
        for (int i = 0; i < 5; i++) rand_px(1'b1);
        idle(3);
        for (int i = 0; i < 4; i++) rand_px(1'b1);
        mid_reset();
        for (int i = 0; i < 6; i++) rand_px(1'b1);

        for (int i = 0; i < 300; i++) rand_px($urandom_range(0, 4) != 0);
        idle(LAT + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
